// File: rtl/adc_seq_pkg.sv
// Shared types and defaults for the ADC frame sequencer.
package adc_seq_pkg;

  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_COLLECT = 2'd2
  } seq_state_e;

  // Channel field width; a single-channel build still gets a 1-bit field.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_cnv_divider.sv
// Conversion-start cadence generator: one cnv_start pulse every max(period,2) cycles.
module adc_cnv_divider #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  output logic             cnv_start
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] len_q, len_d;
  logic [DIV_W-1:0] eff_period;

  always_comb begin
    eff_period = (period < DIV_W'(2)) ? DIV_W'(2) : period;
  end

  // The period length is captured whenever the count sits at 0, so a new
  // period value only applies from the next wrap onwards.
  always_comb begin
    len_d     = (cnt_q == '0) ? eff_period : len_q;
    cnv_start = enable && (cnt_q == (len_d - DIV_W'(1)));
    if (!enable || cnv_start) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

endmodule

// File: rtl/adc_frame_sequencer.sv
// ADC frame sequencer: conversion cadence, channel-order checking, frame
// assembly and a single-entry valid/ready output register.
module adc_frame_sequencer
  import adc_seq_pkg::*;
#(
  parameter  int unsigned NUM_CH = NUM_CH_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DIV_W  = 8,
  parameter  int unsigned IDX_W  = 32,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned CH_W   = ch_width(NUM_CH)
) (
  input  logic                     aclk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         period,
  output logic                     cnv_start,
  input  logic [DATA_W-1:0]        adc_data,
  input  logic [CH_W-1:0]          adc_channel,
  input  logic                     adc_new_samp,
  output logic [NUM_CH*DATA_W-1:0] frame_data,
  output logic [IDX_W-1:0]         frame_index,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [CNT_W-1:0]         overflow_cnt,
  output logic                     seq_err,
  output logic                     busy
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  seq_state_e                     state_q, state_d;
  logic [CH_W-1:0]                exp_q, exp_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  buf_q, buf_d, asm;
  logic [NUM_CH-1:0][DATA_W-1:0]  frame_q, frame_d;
  logic [IDX_W-1:0]               next_idx_q, next_idx_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           fv_q, fv_d;
  logic [CNT_W-1:0]               ovf_q, ovf_d;
  logic                           err_q, err_d;
  logic                           complete;

  adc_cnv_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .aclk      (aclk),
    .rst       (rst),
    .enable    (enable),
    .period    (period),
    .cnv_start (cnv_start)
  );

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    buf_d    = buf_q;
    err_d    = err_q;
    asm      = buf_q;
    complete = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!enable) begin
          state_d = ST_IDLE;
          exp_d   = '0;
          buf_d   = '0;
        end else if (adc_new_samp && (adc_channel == '0)) begin
          buf_d    = '0;
          buf_d[0] = adc_data;
          exp_d    = CH_W'(1);
          state_d  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (!enable) begin
          state_d = ST_IDLE;
          exp_d   = '0;
          buf_d   = '0;
        end else if (adc_new_samp) begin
          if (adc_channel == exp_q) begin
            asm[exp_q] = adc_data;
            if (exp_q == LAST_CH) begin
              complete = 1'b1;
              exp_d    = '0;
              buf_d    = '0;
            end else begin
              buf_d = asm;
              exp_d = exp_q + 1'b1;
            end
          end else begin
            // Out-of-order sample: a channel-0 sample can seed a fresh frame
            // directly, anything else forces a resync.
            err_d = 1'b1;
            buf_d = '0;
            if (adc_channel == '0) begin
              buf_d[0] = adc_data;
              exp_d    = CH_W'(1);
            end else begin
              exp_d   = '0;
              state_d = ST_SYNC;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        exp_d   = '0;
        buf_d   = '0;
      end
    endcase
  end

  always_comb begin
    frame_d    = frame_q;
    idx_d      = idx_q;
    fv_d       = fv_q;
    next_idx_d = next_idx_q;
    ovf_d      = ovf_q;
    if (complete) begin
      if (!fv_q || frame_ready) begin
        frame_d    = asm;
        idx_d      = next_idx_q;
        fv_d       = 1'b1;
        next_idx_d = next_idx_q + 1'b1;
      end else if (ovf_q != '1) begin
        ovf_d = ovf_q + 1'b1;
      end
    end else if (fv_q && frame_ready) begin
      fv_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      exp_q      <= '0;
      buf_q      <= '0;
      frame_q    <= '0;
      idx_q      <= '0;
      fv_q       <= 1'b0;
      next_idx_q <= '0;
      ovf_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      buf_q      <= buf_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      fv_q       <= fv_d;
      next_idx_q <= next_idx_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign frame_data   = frame_q;
  assign frame_index  = idx_q;
  assign frame_valid  = fv_q;
  assign overflow_cnt = ovf_q;
  assign seq_err      = err_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
